watch_time_counter: RTL and testbench
=====================================

// Module: watch_time_counter
// PURPOSE
//  BCD time-of-day counter for the digital watch. Counts seconds, minutes and hours on a
//  1 Hz tick and exposes six 4-bit BCD digits, each feeding one 7-segment decoder.
//  Includes a button-driven set mode (hours, then minutes) and a day-rollover pulse.
//  Sits directly upstream of the per-digit 7-segment decoders.
// PARAMETERS
//  HOURS_24   1   1 = hours 00..23; 0 = 12-hour mode, hours 01..12 with pm flag
// PORTS
//  clk         in   1  system clock; all logic rising-edge
//  rst_n       in   1  asynchronous, active-low reset
//  tick_1hz    in   1  one-cycle pulse, once per second
//  btn_mode    in   1  one-cycle pulse (debounced upstream): advance mode
//  btn_inc     in   1  one-cycle pulse (debounced upstream): increment selected field
//  hr_tens     out  4  BCD hours tens digit
//  hr_ones     out  4  BCD hours ones digit
//  min_tens    out  4  BCD minutes tens digit
//  min_ones    out  4  BCD minutes ones digit
//  sec_tens    out  4  BCD seconds tens digit
//  sec_ones    out  4  BCD seconds ones digit
//  pm          out  1  12-hour mode only: 1 = PM; tied 0 when HOURS_24=1
//  set_hr      out  1  1 while in SET_HR (drives digit blink)
//  set_min     out  1  1 while in SET_MIN
//  day_carry   out  1  one-cycle pulse on midnight rollover
// BEHAVIOUR
//  - Reset (async, rst_n=0): state RUN; time 00:00:00 (HOURS_24=1) or 12:00:00 pm=0;
//    set_hr=set_min=day_carry=0. Every input is sampled on clk only.
//  - All outputs registered; an accepted event is visible the cycle after the sampling edge.
//  - Every digit is always valid BCD (0..9; tens of sec/min 0..5; hr_tens 0..2).
//  - FSM: RUN -btn_mode-> SET_HR -btn_mode-> SET_MIN -btn_mode-> RUN.
//  - RUN, tick_1hz=1: seconds +1. 59->00 carries to minutes; minutes 59->00 carries to hours.
//    24h: hours 23->00 on carry, day_carry=1 for one cycle.
//    12h: 11->12 toggles pm; 12->01; day_carry=1 only on 11:59:59 pm -> 12:00:00 am.
//  - SET_HR / SET_MIN: tick_1hz ignored (time frozen). btn_inc increments only the selected
//    field with wrap (hours 23->00 / 12->01, minutes 59->00); no carry into other fields,
//    day_carry stays 0. 12h: hours 11->12 via btn_inc toggles pm.
//  - Leaving SET_MIN (-> RUN) clears seconds to 00 on the same edge.
//  - Simultaneous events:
//    btn_mode+btn_inc same cycle: mode change wins, increment discarded.
//    RUN, btn_mode+tick_1hz: tick applied and state -> SET_HR on the same edge.
//    SET_MIN, btn_mode+tick_1hz: -> RUN, seconds=00, tick discarded.
//  - rst_n asserted mid-operation (any state): immediate return to reset values.
//  - day_carry never asserted for two consecutive cycles.
// TESTING
//  1 Reset: hold rst_n=0 mid-count -> all digits 0, set_hr=set_min=0 immediately (async).
//  2 Preset via set mode to 23:59, run to :59, one tick -> 00:00:00, day_carry=1 for exactly 1 cycle.
//  3 RUN at 00:00:59, tick -> 00:01:00; at 00:59:59 tick -> 01:00:00; digits stay BCD throughout.
//  4 btn_mode -> set_hr=1; 5x btn_inc from 22 -> 03; ticks during SET_HR leave seconds unchanged.
//  5 SET_MIN at 59, btn_inc -> 00 with hours unchanged; btn_mode+btn_inc same cycle -> RUN, min unchanged, sec=00.
//  6 HOURS_24=0: 11:59:59 am tick -> 12:00:00 pm=1, day_carry=0; 12:59:59 tick -> 01:00:00.

Source files
------------

// File: rtl/watch_time_counter.sv
// BCD time-of-day counter with hour/minute set mode and a midnight rollover pulse.
// Latency: one cycle; a sampled tick or button shows on the outputs after the next rising edge.
// Backpressure: none; every input pulse is acted on in the cycle it arrives.
module watch_time_counter #(
    parameter int HOURS_24 = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_inc,
    output logic [3:0] hr_tens,
    output logic [3:0] hr_ones,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       pm,
    output logic       set_hr,
    output logic       set_min,
    output logic       day_carry
);

    typedef enum logic [1:0] {RUN, SET_HR, SET_MIN} state_t;

    typedef struct packed {
        logic [3:0] ht;
        logic [3:0] ho;
        logic [3:0] mt;
        logic [3:0] mo;
        logic [3:0] st;
        logic [3:0] so;
        logic       pm;
    } tod_t;

    typedef struct packed {
        logic [3:0] t;
        logic [3:0] o;
        logic       wrap;
    } bcd60_t;

    typedef struct packed {
        logic [3:0] t;
        logic [3:0] o;
        logic       pm;
        logic       day;
    } hr_t;

    localparam logic [3:0] RST_HT = (HOURS_24 != 0) ? 4'd0 : 4'd1;
    localparam logic [3:0] RST_HO = (HOURS_24 != 0) ? 4'd0 : 4'd2;
    localparam tod_t TOD_RST = '{ht: RST_HT, ho: RST_HO, mt: 4'd0, mo: 4'd0,
                                 st: 4'd0, so: 4'd0, pm: 1'b0};

    function automatic bcd60_t inc60(input logic [3:0] t, input logic [3:0] o);
        bcd60_t r;
        r.t    = t;
        r.o    = o + 4'd1;
        r.wrap = 1'b0;
        if (o == 4'd9) begin
            r.o = 4'd0;
            if (t == 4'd5) begin
                r.t    = 4'd0;
                r.wrap = 1'b1;
            end else begin
                r.t = t + 4'd1;
            end
        end
        return r;
    endfunction

    // day flags the midnight crossing; only the running path forwards it.
    function automatic hr_t inc_hr(input logic [3:0] t, input logic [3:0] o, input logic p);
        hr_t r;
        r.t   = t;
        r.o   = o + 4'd1;
        r.pm  = p;
        r.day = 1'b0;
        if (HOURS_24 != 0) begin
            if (t == 4'd2 && o == 4'd3) begin
                r.t   = 4'd0;
                r.o   = 4'd0;
                r.day = 1'b1;
            end else if (o == 4'd9) begin
                r.t = t + 4'd1;
                r.o = 4'd0;
            end
        end else begin
            if (t == 4'd1 && o == 4'd2) begin
                r.t = 4'd0;
                r.o = 4'd1;
            end else if (t == 4'd1 && o == 4'd1) begin
                r.o   = 4'd2;
                r.pm  = ~p;
                r.day = p;
            end else if (o == 4'd9) begin
                r.t = 4'd1;
                r.o = 4'd0;
            end
        end
        return r;
    endfunction

    state_t state_q, state_d;
    tod_t   tod_q, tod_d;
    logic   dc_q, dc_d;
    bcd60_t sec_inc, min_inc;
    hr_t    hr_inc;

    assign sec_inc = inc60(tod_q.st, tod_q.so);
    assign min_inc = inc60(tod_q.mt, tod_q.mo);
    assign hr_inc  = inc_hr(tod_q.ht, tod_q.ho, tod_q.pm);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            tod_q   <= TOD_RST;
            dc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            tod_q   <= tod_d;
            dc_q    <= dc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tod_d   = tod_q;
        dc_d    = 1'b0;
        case (state_q)
            RUN: begin
                if (tick_1hz) begin
                    tod_d.st = sec_inc.t;
                    tod_d.so = sec_inc.o;
                    if (sec_inc.wrap) begin
                        tod_d.mt = min_inc.t;
                        tod_d.mo = min_inc.o;
                        if (min_inc.wrap) begin
                            tod_d.ht = hr_inc.t;
                            tod_d.ho = hr_inc.o;
                            tod_d.pm = hr_inc.pm;
                            dc_d     = hr_inc.day;
                        end
                    end
                end
                if (btn_mode) state_d = SET_HR;
            end
            SET_HR: begin
                if (btn_mode) begin
                    state_d = SET_MIN;
                end else if (btn_inc) begin
                    tod_d.ht = hr_inc.t;
                    tod_d.ho = hr_inc.o;
                    tod_d.pm = hr_inc.pm;
                end
            end
            SET_MIN: begin
                // Leaving set mode restarts the minute cleanly; a coincident tick is dropped.
                if (btn_mode) begin
                    state_d  = RUN;
                    tod_d.st = 4'd0;
                    tod_d.so = 4'd0;
                end else if (btn_inc) begin
                    tod_d.mt = min_inc.t;
                    tod_d.mo = min_inc.o;
                end
            end
            default: state_d = RUN;
        endcase
    end

    assign hr_tens   = tod_q.ht;
    assign hr_ones   = tod_q.ho;
    assign min_tens  = tod_q.mt;
    assign min_ones  = tod_q.mo;
    assign sec_tens  = tod_q.st;
    assign sec_ones  = tod_q.so;
    assign pm        = (HOURS_24 != 0) ? 1'b0 : tod_q.pm;
    assign set_hr    = (state_q == SET_HR);
    assign set_min   = (state_q == SET_MIN);
    assign day_carry = dc_q;

endmodule

// File: tb/tb_watch_time_counter.sv
// Directed table-driven bench for watch_time_counter in 24-hour and 12-hour builds.
module tb_watch_time_counter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic m24 = 1'b0, i24 = 1'b0, t24 = 1'b0;
    logic m12 = 1'b0, i12 = 1'b0, t12 = 1'b0;

    logic [3:0] a_ht, a_ho, a_mt, a_mo, a_st, a_so;
    logic       a_pm, a_sh, a_sm, a_dc;
    logic [3:0] b_ht, b_ho, b_mt, b_mo, b_st, b_so;
    logic       b_pm, b_sh, b_sm, b_dc;

    int ncmp = 0;
    int nfail = 0;
    logic prev_dc24 = 1'b0, prev_dc12 = 1'b0;

    always #5 clk = ~clk;

    watch_time_counter #(.HOURS_24(1)) dut24 (
        .clk(clk), .rst_n(rst_n), .tick_1hz(t24), .btn_mode(m24), .btn_inc(i24),
        .hr_tens(a_ht), .hr_ones(a_ho), .min_tens(a_mt), .min_ones(a_mo),
        .sec_tens(a_st), .sec_ones(a_so), .pm(a_pm), .set_hr(a_sh), .set_min(a_sm),
        .day_carry(a_dc)
    );

    watch_time_counter #(.HOURS_24(0)) dut12 (
        .clk(clk), .rst_n(rst_n), .tick_1hz(t12), .btn_mode(m12), .btn_inc(i12),
        .hr_tens(b_ht), .hr_ones(b_ho), .min_tens(b_mt), .min_ones(b_mo),
        .sec_tens(b_st), .sec_ones(b_so), .pm(b_pm), .set_hr(b_sh), .set_min(b_sm),
        .day_carry(b_dc)
    );

    typedef struct {
        int          n;
        logic        m, i, t;
        logic [23:0] tod;
        logic        pm, sh, sm, dc;
    } vec_t;

    function automatic vec_t mk(input int n, input logic m, input logic i, input logic t,
                                input logic [23:0] tod, input logic pm, input logic sh,
                                input logic sm, input logic dc);
        vec_t v;
        v.n = n; v.m = m; v.i = i; v.t = t;
        v.tod = tod; v.pm = pm; v.sh = sh; v.sm = sm; v.dc = dc;
        return v;
    endfunction

    function automatic logic [27:0] got_state(input bit sel);
        if (sel) return {b_ht, b_ho, b_mt, b_mo, b_st, b_so, b_pm, b_sh, b_sm, b_dc};
        return {a_ht, a_ho, a_mt, a_mo, a_st, a_so, a_pm, a_sh, a_sm, a_dc};
    endfunction

    task automatic compare(input string name, input logic [27:0] got, input logic [27:0] exp);
        ncmp++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got tod=%h pm/sh/sm/dc=%b, want tod=%h pm/sh/sm/dc=%b",
                     name, got[27:4], got[3:0], exp[27:4], exp[3:0]);
        end
    endtask

    // Digit ranges and single-cycle day_carry are checked on every clocked cycle.
    task automatic check_cycle(input bit sel);
        logic [27:0] g;
        logic        prev;
        logic        ok;
        g    = got_state(sel);
        prev = sel ? prev_dc12 : prev_dc24;
        ok   = (g[27:24] <= 4'd2) && (g[23:20] <= 4'd9) && (g[19:16] <= 4'd5) &&
               (g[15:12] <= 4'd9) && (g[11:8] <= 4'd5) && (g[7:4] <= 4'd9) &&
               !(prev && g[0]);
        ncmp++;
        if (!ok) begin
            nfail++;
            $display("FAIL bcd_range dut%0d: got tod=%h dc=%b prev_dc=%b, want BCD digits and no back-to-back dc",
                     sel ? 12 : 24, g[27:4], g[0], prev);
        end
        if (sel) prev_dc12 = g[0];
        else     prev_dc24 = g[0];
    endtask

    task automatic apply(input bit sel, input vec_t v, input string name);
        for (int k = 0; k < v.n; k++) begin
            if (sel) begin m12 = v.m; i12 = v.i; t12 = v.t; end
            else     begin m24 = v.m; i24 = v.i; t24 = v.t; end
            @(posedge clk);
            #1;
            {m24, i24, t24, m12, i12, t12} = 6'b0;
            check_cycle(sel);
        end
        compare(name, got_state(sel), {v.tod, v.pm, v.sh, v.sm, v.dc});
    endtask

    vec_t v24[$];
    vec_t v12[$];

    initial begin
        // 24-hour build: n, mode, inc, tick, expected tod, pm, set_hr, set_min, day_carry
        v24.push_back(mk(59, 0, 0, 1, 24'h000059, 0, 0, 0, 0));
        v24.push_back(mk(1,  0, 0, 1, 24'h000100, 0, 0, 0, 0));
        v24.push_back(mk(1,  1, 0, 0, 24'h000100, 0, 1, 0, 0));
        v24.push_back(mk(1,  1, 0, 0, 24'h000100, 0, 0, 1, 0));
        v24.push_back(mk(58, 0, 1, 0, 24'h005900, 0, 0, 1, 0));
        v24.push_back(mk(1,  1, 0, 0, 24'h005900, 0, 0, 0, 0));
        v24.push_back(mk(59, 0, 0, 1, 24'h005959, 0, 0, 0, 0));
        v24.push_back(mk(1,  0, 0, 1, 24'h010000, 0, 0, 0, 0));
        v24.push_back(mk(1,  1, 0, 1, 24'h010001, 0, 1, 0, 0));
        v24.push_back(mk(1,  0, 0, 1, 24'h010001, 0, 1, 0, 0));
        v24.push_back(mk(1,  0, 1, 0, 24'h020001, 0, 1, 0, 0));
        v24.push_back(mk(1,  1, 1, 0, 24'h020001, 0, 0, 1, 0));
        v24.push_back(mk(1,  0, 1, 0, 24'h020101, 0, 0, 1, 0));
        v24.push_back(mk(1,  0, 0, 1, 24'h020101, 0, 0, 1, 0));
        v24.push_back(mk(1,  1, 0, 1, 24'h020100, 0, 0, 0, 0));
        v24.push_back(mk(1,  0, 1, 1, 24'h020101, 0, 0, 0, 0));
        v24.push_back(mk(1,  1, 0, 0, 24'h020101, 0, 1, 0, 0));
        v24.push_back(mk(20, 0, 1, 0, 24'h220101, 0, 1, 0, 0));
        v24.push_back(mk(1,  0, 1, 0, 24'h230101, 0, 1, 0, 0));
        v24.push_back(mk(1,  0, 1, 0, 24'h000101, 0, 1, 0, 0));
        v24.push_back(mk(1,  0, 1, 0, 24'h010101, 0, 1, 0, 0));
        v24.push_back(mk(1,  0, 1, 0, 24'h020101, 0, 1, 0, 0));
        v24.push_back(mk(1,  0, 1, 0, 24'h030101, 0, 1, 0, 0));
        v24.push_back(mk(3,  0, 0, 1, 24'h030101, 0, 1, 0, 0));
        v24.push_back(mk(1,  1, 0, 0, 24'h030101, 0, 0, 1, 0));
        v24.push_back(mk(58, 0, 1, 0, 24'h035901, 0, 0, 1, 0));
        v24.push_back(mk(1,  0, 1, 0, 24'h030001, 0, 0, 1, 0));
        v24.push_back(mk(59, 0, 1, 0, 24'h035901, 0, 0, 1, 0));
        v24.push_back(mk(1,  1, 1, 0, 24'h035900, 0, 0, 0, 0));
        v24.push_back(mk(1,  1, 0, 0, 24'h035900, 0, 1, 0, 0));
        v24.push_back(mk(20, 0, 1, 0, 24'h235900, 0, 1, 0, 0));
        v24.push_back(mk(1,  1, 0, 0, 24'h235900, 0, 0, 1, 0));
        v24.push_back(mk(1,  1, 0, 0, 24'h235900, 0, 0, 0, 0));
        v24.push_back(mk(59, 0, 0, 1, 24'h235959, 0, 0, 0, 0));
        v24.push_back(mk(1,  0, 0, 1, 24'h000000, 0, 0, 0, 1));
        v24.push_back(mk(1,  0, 0, 0, 24'h000000, 0, 0, 0, 0));
        v24.push_back(mk(1,  0, 0, 1, 24'h000001, 0, 0, 0, 0));
        v24.push_back(mk(1,  1, 0, 1, 24'h000002, 0, 1, 0, 0));

        // 12-hour build from 12:00:00 am
        v12.push_back(mk(1,  1, 0, 0, 24'h120000, 0, 1, 0, 0));
        v12.push_back(mk(1,  0, 1, 0, 24'h010000, 0, 1, 0, 0));
        v12.push_back(mk(10, 0, 1, 0, 24'h110000, 0, 1, 0, 0));
        v12.push_back(mk(1,  1, 0, 0, 24'h110000, 0, 0, 1, 0));
        v12.push_back(mk(59, 0, 1, 0, 24'h115900, 0, 0, 1, 0));
        v12.push_back(mk(1,  1, 0, 0, 24'h115900, 0, 0, 0, 0));
        v12.push_back(mk(59, 0, 0, 1, 24'h115959, 0, 0, 0, 0));
        v12.push_back(mk(1,  0, 0, 1, 24'h120000, 1, 0, 0, 0));
        v12.push_back(mk(1,  1, 0, 0, 24'h120000, 1, 1, 0, 0));
        v12.push_back(mk(1,  1, 0, 0, 24'h120000, 1, 0, 1, 0));
        v12.push_back(mk(59, 0, 1, 0, 24'h125900, 1, 0, 1, 0));
        v12.push_back(mk(1,  1, 0, 0, 24'h125900, 1, 0, 0, 0));
        v12.push_back(mk(59, 0, 0, 1, 24'h125959, 1, 0, 0, 0));
        v12.push_back(mk(1,  0, 0, 1, 24'h010000, 1, 0, 0, 0));
        v12.push_back(mk(1,  1, 0, 0, 24'h010000, 1, 1, 0, 0));
        v12.push_back(mk(10, 0, 1, 0, 24'h110000, 1, 1, 0, 0));
        v12.push_back(mk(1,  1, 0, 0, 24'h110000, 1, 0, 1, 0));
        v12.push_back(mk(59, 0, 1, 0, 24'h115900, 1, 0, 1, 0));
        v12.push_back(mk(1,  1, 0, 0, 24'h115900, 1, 0, 0, 0));
        v12.push_back(mk(59, 0, 0, 1, 24'h115959, 1, 0, 0, 0));
        v12.push_back(mk(1,  0, 0, 1, 24'h120000, 0, 0, 0, 1));
        v12.push_back(mk(1,  0, 0, 0, 24'h120000, 0, 0, 0, 0));
        v12.push_back(mk(1,  1, 0, 0, 24'h120000, 0, 1, 0, 0));
        v12.push_back(mk(11, 0, 1, 0, 24'h110000, 0, 1, 0, 0));
        v12.push_back(mk(1,  0, 1, 0, 24'h120000, 1, 1, 0, 0));
        v12.push_back(mk(1,  0, 1, 0, 24'h010000, 1, 1, 0, 0));

        #12;
        compare("reset24", got_state(0), {24'h000000, 4'b0000});
        compare("reset12", got_state(1), {24'h120000, 4'b0000});
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < v24.size(); k++)
            apply(0, v24[k], $sformatf("v24[%0d]", k));

        // Asynchronous reset between clock edges, while in SET_HR with a nonzero time.
        #2;
        rst_n = 1'b0;
        #1;
        compare("async_rst24", got_state(0), {24'h000000, 4'b0000});
        compare("async_rst12", got_state(1), {24'h120000, 4'b0000});
        prev_dc24 = 1'b0;
        prev_dc12 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < v12.size(); k++)
            apply(1, v12[k], $sformatf("v12[%0d]", k));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
